mer_accum: RTL and testbench

Symbol-rate MER measurement accumulator that sits directly downstream of the symbol-compare/error stage. Per symbol it squares the slicer error and the mapper reference level, sums both over a window of 2^WINDOW_LOG2 symbols, and counts symbol errors. At each window end it latches the mean error power, mean reference power and symbol-error count for the MER readout/display logic.

---
 rtl/mer_accum_if.sv | 42 ++++
 rtl/mer_accum.sv | 132 +++++++++++++
 tb/tb_mer_accum.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mer_accum_if.sv
// mer_accum symbol-side and result-side signal bundle.
// master drives symbols, slave is the accumulator.
interface mer_accum_if #(
  parameter int WINDOW_LOG2 = 10
);
  logic                     sym_clk_en;
  logic                     clear_accum;
  logic signed [17:0]       error;
  logic signed [17:0]       map_out;
  logic                     sym_error;
  logic [35:0]              err_power;
  logic [35:0]              ref_power;
  logic [WINDOW_LOG2:0]     sym_err_count;
  logic                     results_valid;
  logic                     busy;

  modport master (
    output sym_clk_en,
    output clear_accum,
    output error,
    output map_out,
    output sym_error,
    input  err_power,
    input  ref_power,
    input  sym_err_count,
    input  results_valid,
    input  busy
  );

  modport slave (
    input  sym_clk_en,
    input  clear_accum,
    input  error,
    input  map_out,
    input  sym_error,
    output err_power,
    output ref_power,
    output sym_err_count,
    output results_valid,
    output busy
  );
endinterface

// File: rtl/mer_accum.sv
// MER window accumulator: mean error/reference power per 2^WINDOW_LOG2 symbols.
// Define MER_SYM_ERR_COUNT_EN to build the symbol-error counter.
module mer_accum #(
  parameter int WINDOW_LOG2 = 10
) (
  input logic       clk,
  input logic       reset,
  mer_accum_if.slave bus
);
  localparam int AW = 36 + WINDOW_LOG2;
  localparam int CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] FULL = {1'b1, {WINDOW_LOG2{1'b0}}};
  localparam logic [CW-1:0] ONE  = {{WINDOW_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DUMP
  } state_t;

  state_t state;
  state_t next_state;

  logic              v1;
  logic [35:0]       e_sq;
  logic [35:0]       r_sq;
  logic [AW-1:0]     err_acc;
  logic [AW-1:0]     ref_acc;
  logic [CW-1:0]     sym_cnt;
  logic signed [35:0] e_ext;
  logic signed [35:0] m_ext;
  logic signed [35:0] e_prod;
  logic signed [35:0] r_prod;
  logic              cap;
  logic              zero;
  logic              win_end;

  assign e_ext  = {{18{bus.error[17]}}, bus.error};
  assign m_ext  = {{18{bus.map_out[17]}}, bus.map_out};
  assign e_prod = e_ext * e_ext;
  assign r_prod = m_ext * m_ext;

  // DUMP still captures so a symbol landing there joins the next window
  assign cap  = bus.sym_clk_en && !bus.clear_accum
             && (state != IDLE);
  assign zero = (state == IDLE) || bus.clear_accum;
  assign win_end = (state == ACCUM) && v1
                && (sym_cnt + ONE == FULL);
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.clear_accum) next_state = ACCUM;
      ACCUM:   if (!bus.clear_accum && win_end)
                 next_state = DUMP;
      DUMP:    next_state = ACCUM;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1                <= 1'b0;
      e_sq              <= '0;
      r_sq              <= '0;
      err_acc           <= '0;
      ref_acc           <= '0;
      sym_cnt           <= '0;
      bus.err_power     <= '0;
      bus.ref_power     <= '0;
      bus.results_valid <= 1'b0;
    end else begin
      v1                <= cap;
      bus.results_valid <= 1'b0;
      if (cap) begin
        e_sq <= e_prod;
        r_sq <= r_prod;
      end
      if (zero) begin
        err_acc <= '0;
        ref_acc <= '0;
        sym_cnt <= '0;
      end else if (state == DUMP) begin
        bus.err_power     <= err_acc[AW-1:WINDOW_LOG2];
        bus.ref_power     <= ref_acc[AW-1:WINDOW_LOG2];
        bus.results_valid <= 1'b1;
        err_acc <= v1 ? {{WINDOW_LOG2{1'b0}}, e_sq} : '0;
        ref_acc <= v1 ? {{WINDOW_LOG2{1'b0}}, r_sq} : '0;
        sym_cnt <= v1 ? ONE : '0;
      end else if (v1) begin
        err_acc <= err_acc + {{WINDOW_LOG2{1'b0}}, e_sq};
        ref_acc <= ref_acc + {{WINDOW_LOG2{1'b0}}, r_sq};
        sym_cnt <= sym_cnt + ONE;
      end
    end
  end

`ifdef MER_SYM_ERR_COUNT_EN
  logic          err_bit;
  logic [CW-1:0] err_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_bit           <= 1'b0;
      err_cnt           <= '0;
      bus.sym_err_count <= '0;
    end else begin
      if (cap) err_bit <= bus.sym_error;
      if (zero) begin
        err_cnt <= '0;
      end else if (state == DUMP) begin
        bus.sym_err_count <= err_cnt;
        err_cnt <= v1 ? {{WINDOW_LOG2{1'b0}}, err_bit}
                      : '0;
      end else if (v1) begin
        err_cnt <= err_cnt
                 + {{WINDOW_LOG2{1'b0}}, err_bit};
      end
    end
  end
`else
  logic unused_sym_error;
  assign unused_sym_error  = bus.sym_error;
  assign bus.sym_err_count = '0;
`endif
endmodule

// File: tb/tb_mer_accum.sv
// Self-checking bench for mer_accum, WINDOW_LOG2 = 4.
// Windows are modelled as consecutive 16-symbol chunks since the last clear.
module tb_mer_accum;
  localparam int W = 4;
  localparam int N = 16;

  typedef struct packed {
    logic [35:0] ep;
    logic [35:0] rp;
    logic [W:0]  cnt;
  } res_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  res_t obs[$];
  int   q_e[$];
  int   q_m[$];
  int   q_s[$];

  mer_accum_if #(.WINDOW_LOG2(W)) bus ();

  mer_accum #(.WINDOW_LOG2(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.results_valid === 1'b1)
      obs.push_back({bus.err_power, bus.ref_power,
                     bus.sym_err_count});
  end

  function automatic int exp_cnt(input int c);
`ifdef MER_SYM_ERR_COUNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  function automatic int rnd18();
    logic signed [17:0] r;
    r = 18'($urandom);
    return int'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int e, input int m, input bit se);
    bus.error     = 18'(e);
    bus.map_out   = 18'(m);
    bus.sym_error = se;
  endtask

  task automatic sym(input int e, input int m, input bit se,
                     input int gap);
    drive(e, m, se);
    bus.sym_clk_en = 1'b1;
    tick();
    bus.sym_clk_en = 1'b0;
    repeat (gap - 1) tick();
    q_e.push_back(e);
    q_m.push_back(m);
    q_s.push_back(int'(se));
  endtask

  task automatic start_window();
    q_e.delete();
    q_m.delete();
    q_s.delete();
    bus.clear_accum = 1'b1;
    tick();
    bus.clear_accum = 1'b0;
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_clear got %b want 1", bus.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rnd18(), rnd18(), 1'($urandom));
      bus.sym_clk_en  = 1'($urandom);
      bus.clear_accum = 1'($urandom);
      tick();
    end
    bus.sym_clk_en  = 1'b0;
    bus.clear_accum = 1'b0;
    tests += 5;
    if (bus.err_power !== 36'd0) begin
      fails++;
      $display("FAIL rst_err_power got %h want 0", bus.err_power);
    end
    if (bus.ref_power !== 36'd0) begin
      fails++;
      $display("FAIL rst_ref_power got %h want 0", bus.ref_power);
    end
    if (bus.sym_err_count !== '0) begin
      fails++;
      $display("FAIL rst_count got %0d want 0", bus.sym_err_count);
    end
    if (bus.results_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %b want 0", bus.results_valid);
    end
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    reset = 1'b1;
    obs.delete();
    for (int i = 0; i < 20; i++)
      sym(rnd18(), rnd18(), 1'b0, 2);
    repeat (4) tick();
    tests += 2;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy got %b want 0", bus.busy);
    end
    if (obs.size() != 0) begin
      fails++;
      $display("FAIL idle_results got %0d want 0", obs.size());
    end
  endtask

  task automatic test_basic();
    int e;
    int m;
    e = 'h08000;
    m = 'h0C000;
    start_window();
    obs.delete();
    for (int i = 0; i < N - 1; i++)
      sym(e, m, (i == 2 || i == 7 || i == 11), 4);
    drive(e, m, 1'b0);
    bus.sym_clk_en = 1'b1;
    tick();
    bus.sym_clk_en = 1'b0;
    tick();
    tests++;
    if (bus.results_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat_e1 got %b want 0", bus.results_valid);
    end
    tick();
    tests += 4;
    if (bus.results_valid !== 1'b1) begin
      fails++;
      $display("FAIL lat_e2 got %b want 1", bus.results_valid);
    end
    if (bus.err_power !== 36'h040000000) begin
      fails++;
      $display("FAIL basic_err got %h want 040000000",
               bus.err_power);
    end
    if (bus.ref_power !== 36'h090000000) begin
      fails++;
      $display("FAIL basic_ref got %h want 090000000",
               bus.ref_power);
    end
    if (int'(bus.sym_err_count) != exp_cnt(3)) begin
      fails++;
      $display("FAIL basic_cnt got %0d want %0d",
               bus.sym_err_count, exp_cnt(3));
    end
    tick();
    tests += 2;
    if (bus.results_valid !== 1'b0) begin
      fails++;
      $display("FAIL pulse_width got %b want 0", bus.results_valid);
    end
    repeat (4) tick();
    if (obs.size() != 1) begin
      fails++;
      $display("FAIL basic_pulses got %0d want 1", obs.size());
    end
  endtask

  task automatic test_negative();
    longint rs;
    start_window();
    obs.delete();
    rs = 0;
    for (int i = 0; i < N; i++) begin
      int m;
      m = rnd18();
      rs += longint'(m) * longint'(m);
      sym(-131072, m, 1'b0, 3);
    end
    repeat (4) tick();
    tests += 3;
    if (obs.size() != 1) begin
      fails++;
      $display("FAIL neg_pulses got %0d want 1", obs.size());
    end else begin
      if (obs[0].ep !== 36'h400000000) begin
        fails++;
        $display("FAIL neg_err got %h want 400000000", obs[0].ep);
      end
      if (obs[0].rp !== 36'(rs >> W)) begin
        fails++;
        $display("FAIL neg_ref got %h want %h",
                 obs[0].rp, 36'(rs >> W));
      end
    end
  endtask

  task automatic test_clear_mid();
    logic [35:0] prev;
    longint rs;
    start_window();
    obs.delete();
    for (int i = 0; i < 10; i++)
      sym(rnd18(), rnd18(), 1'($urandom), 3);
    prev = bus.err_power;
    start_window();
    tests++;
    if (bus.err_power !== prev) begin
      fails++;
      $display("FAIL clear_hold got %h want %h",
               bus.err_power, prev);
    end
    rs = 0;
    for (int i = 0; i < N; i++) begin
      int m;
      m = rnd18();
      rs += longint'(m) * longint'(m);
      sym('h04000, m, 1'b0, 2);
    end
    repeat (4) tick();
    tests += 4;
    if (obs.size() != 1) begin
      fails++;
      $display("FAIL clear_pulses got %0d want 1", obs.size());
    end else begin
      if (obs[0].ep !== 36'h010000000) begin
        fails++;
        $display("FAIL clear_err got %h want 010000000", obs[0].ep);
      end
      if (obs[0].rp !== 36'(rs >> W)) begin
        fails++;
        $display("FAIL clear_ref got %h want %h",
                 obs[0].rp, 36'(rs >> W));
      end
      if (int'(obs[0].cnt) != 0) begin
        fails++;
        $display("FAIL clear_cnt got %0d want 0", obs[0].cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_window();
    obs.delete();
    for (int i = 0; i < 3 * N + 5; i++) begin
      int gap;
      gap = (i < 2 * N) ? 2 : int'($urandom_range(2, 5));
      sym(rnd18(), rnd18(), 1'($urandom), gap);
    end
    repeat (6) tick();
    tests++;
    if (obs.size() != 3) begin
      fails++;
      $display("FAIL b2b_pulses got %0d want 3", obs.size());
    end
    for (int k = 0; k < 3 && k < obs.size(); k++) begin
      longint es;
      longint rs;
      int     c;
      es = 0;
      rs = 0;
      c  = 0;
      for (int j = k * N; j < (k + 1) * N; j++) begin
        es += longint'(q_e[j]) * longint'(q_e[j]);
        rs += longint'(q_m[j]) * longint'(q_m[j]);
        c  += q_s[j];
      end
      tests += 3;
      if (obs[k].ep !== 36'(es >> W)) begin
        fails++;
        $display("FAIL b2b_err[%0d] got %h want %h",
                 k, obs[k].ep, 36'(es >> W));
      end
      if (obs[k].rp !== 36'(rs >> W)) begin
        fails++;
        $display("FAIL b2b_ref[%0d] got %h want %h",
                 k, obs[k].rp, 36'(rs >> W));
      end
      if (int'(obs[k].cnt) != exp_cnt(c)) begin
        fails++;
        $display("FAIL b2b_cnt[%0d] got %0d want %0d",
                 k, obs[k].cnt, exp_cnt(c));
      end
    end
  endtask

  task automatic test_reset_mid();
    start_window();
    obs.delete();
    for (int i = 0; i < 8; i++)
      sym(rnd18(), rnd18(), 1'b1, 2);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tests += 3;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_busy got %b want 0", bus.busy);
    end
    if (bus.err_power !== 36'd0) begin
      fails++;
      $display("FAIL midrst_err got %h want 0", bus.err_power);
    end
    for (int i = 0; i < 12; i++)
      sym(rnd18(), rnd18(), 1'b1, 2);
    repeat (4) tick();
    if (obs.size() != 0) begin
      fails++;
      $display("FAIL midrst_pulses got %0d want 0", obs.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.sym_clk_en  = 1'b0;
    bus.clear_accum = 1'b0;
    drive(0, 0, 1'b0);
    test_reset();
    test_basic();
    test_negative();
    test_clear_mid();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
